// File: rtl/ex_mem_dreq.sv
// ex_mem_dreq: EX/MEM pipeline register with data-cache request sequencing and stall.
// Define MEM_TIMEOUT_EN to enable the access watchdog (mem_err, forced halt).
module ex_mem_dreq #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pipe3_en,
  input  logic              flushed3,
  input  logic [DATA_W-1:0] npc_i3,
  input  logic [DATA_W-1:0] alu_out_i3,
  input  logic [DATA_W-1:0] rdat2_i3,
  input  logic [DATA_W-1:0] LUI_i3,
  input  logic [1:0]        W_mux_i3,
  input  logic [REG_W-1:0]  wsel_i3,
  input  logic              wen_i3,
  input  logic              d_ren_i3,
  input  logic              d_wen_i3,
  input  logic              halt_i3,
  output logic [DATA_W-1:0] npc_o3,
  output logic [DATA_W-1:0] alu_out_o3,
  output logic [DATA_W-1:0] rdat2_o3,
  output logic [DATA_W-1:0] LUI_o3,
  output logic [1:0]        W_mux_o3,
  output logic [REG_W-1:0]  wsel_o3,
  output logic              wen_o3,
  output logic              halt_o3,
  output logic [DATA_W-1:0] dmemload_o3,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              mem_stall,
  output logic              mem_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic   d_ren_q, d_wen_q;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          expire;
  assign expire = !dhit && cnt == CW'(TIMEOUT_CYC - 1);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign mem_err = 1'b0;
`endif
  assign mem_stall = state == BUSY;
  assign dmemREN   = mem_stall && d_ren_q;
  assign dmemWEN   = mem_stall && d_wen_q;
  assign dmemaddr  = alu_out_o3;
  assign dmemstore = rdat2_o3;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      npc_o3      <= '0;
      alu_out_o3  <= '0;
      rdat2_o3    <= '0;
      LUI_o3      <= '0;
      W_mux_o3    <= '0;
      wsel_o3     <= '0;
      wen_o3      <= 1'b0;
      halt_o3     <= 1'b0;
      dmemload_o3 <= '0;
      d_ren_q     <= 1'b0;
      d_wen_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
      mem_err     <= 1'b0;
`endif
    end else if (state == IDLE) begin
      // a latched halt freezes the stage until reset
      if (!halt_o3 && flushed3) begin
        npc_o3     <= '0;
        alu_out_o3 <= '0;
        rdat2_o3   <= '0;
        LUI_o3     <= '0;
        W_mux_o3   <= '0;
        wsel_o3    <= '0;
        wen_o3     <= 1'b0;
        d_ren_q    <= 1'b0;
        d_wen_q    <= 1'b0;
      end else if (!halt_o3 && pipe3_en) begin
        npc_o3     <= npc_i3;
        alu_out_o3 <= alu_out_i3;
        rdat2_o3   <= rdat2_i3;
        LUI_o3     <= LUI_i3;
        W_mux_o3   <= W_mux_i3;
        wsel_o3    <= wsel_i3;
        wen_o3     <= wen_i3;
        halt_o3    <= halt_i3;
        d_ren_q    <= d_ren_i3 && !d_wen_i3;
        d_wen_q    <= d_wen_i3;
        state      <= (d_ren_i3 || d_wen_i3) ? BUSY : IDLE;
`ifdef MEM_TIMEOUT_EN
        cnt        <= '0;
`endif
      end
    end else if (dhit) begin
      if (d_ren_q) dmemload_o3 <= dmemload;
      state <= IDLE;
    end
`ifdef MEM_TIMEOUT_EN
    else if (expire) begin
      mem_err <= 1'b1;
      halt_o3 <= 1'b1;
      state   <= IDLE;
    end else begin
      cnt <= cnt + 1'b1;
    end
`endif
  end
endmodule

// File: tb/tb_ex_mem_dreq.sv
// tb_ex_mem_dreq: table-driven register checks plus directed load/store/halt/timeout sequences.
module tb_ex_mem_dreq;
  logic        CLK = 0, RST = 1;
  logic        pipe3_en = 0, flushed3 = 0;
  logic [31:0] npc_i3 = 0, alu_out_i3 = 0, rdat2_i3 = 0, LUI_i3 = 0;
  logic [1:0]  W_mux_i3 = 0;
  logic [4:0]  wsel_i3 = 0;
  logic        wen_i3 = 0, d_ren_i3 = 0, d_wen_i3 = 0, halt_i3 = 0;
  logic [31:0] npc_o3, alu_out_o3, rdat2_o3, LUI_o3, dmemload_o3, dmemaddr, dmemstore;
  logic [1:0]  W_mux_o3;
  logic [4:0]  wsel_o3;
  logic        wen_o3, halt_o3, dmemREN, dmemWEN, mem_stall, mem_err;
  logic        dhit = 0;
  logic [31:0] dmemload = 0;
  int checks = 0, errors = 0;

  ex_mem_dreq #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .RST(RST), .pipe3_en(pipe3_en), .flushed3(flushed3),
    .npc_i3(npc_i3), .alu_out_i3(alu_out_i3), .rdat2_i3(rdat2_i3), .LUI_i3(LUI_i3),
    .W_mux_i3(W_mux_i3), .wsel_i3(wsel_i3), .wen_i3(wen_i3), .d_ren_i3(d_ren_i3),
    .d_wen_i3(d_wen_i3), .halt_i3(halt_i3), .npc_o3(npc_o3), .alu_out_o3(alu_out_o3),
    .rdat2_o3(rdat2_o3), .LUI_o3(LUI_o3), .W_mux_o3(W_mux_o3), .wsel_o3(wsel_o3),
    .wen_o3(wen_o3), .halt_o3(halt_o3), .dmemload_o3(dmemload_o3), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic fl, pe;
    logic [31:0] npc, alu, rd2, lui;
    logic [1:0] wm;
    logic [4:0] ws;
    logic we;
    logic [136:0] exp;
  } vec_t;
  vec_t tv[5];

  function automatic logic [136:0] o3();
    return {npc_o3, alu_out_o3, rdat2_o3, LUI_o3, W_mux_o3, wsel_o3, wen_o3, halt_o3};
  endfunction

  task automatic chk(input string nm, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1;
    step();
    RST = 0;
  endtask

  task automatic launch(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    pipe3_en = 1; d_ren_i3 = rd; d_wen_i3 = wr; alu_out_i3 = a; rdat2_i3 = d;
    step();
    pipe3_en = 0; d_ren_i3 = 0; d_wen_i3 = 0;
  endtask

  initial begin
    tv[0] = '{0, 1, 32'h4, 32'h10, 32'h0, 32'h0, 2'd0, 5'd3, 1'b1,
              {32'h4, 32'h10, 32'h0, 32'h0, 2'd0, 5'd3, 1'b1, 1'b0}};
    tv[1] = '{0, 0, 32'h99, 32'h98, 32'h97, 32'h96, 2'd3, 5'd9, 1'b0,
              {32'h4, 32'h10, 32'h0, 32'h0, 2'd0, 5'd3, 1'b1, 1'b0}};
    tv[2] = '{0, 1, 32'h8, 32'hAAAA5555, 32'h11, 32'hFFFF0000, 2'd2, 5'd31, 1'b0,
              {32'h8, 32'hAAAA5555, 32'h11, 32'hFFFF0000, 2'd2, 5'd31, 1'b0, 1'b0}};
    tv[3] = '{1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 2'd1, 5'd1, 1'b1, 137'h0};
    tv[4] = '{0, 1, 32'hC, 32'h7, 32'h5, 32'h1000, 2'd1, 5'd7, 1'b1,
              {32'hC, 32'h7, 32'h5, 32'h1000, 2'd1, 5'd7, 1'b1, 1'b0}};

    // reset with garbage on inputs
    RST = 1; pipe3_en = 1; flushed3 = 0; d_ren_i3 = 1; halt_i3 = 1;
    npc_i3 = $urandom; alu_out_i3 = $urandom; rdat2_i3 = $urandom; LUI_i3 = $urandom;
    dhit = 1; dmemload = $urandom;
    step(); step();
    chk("reset_o3", o3(), 137'h0);
    chk("reset_flags", {mem_stall, dmemREN, dmemWEN, mem_err}, 4'b0);
    chk("reset_load", dmemload_o3, 32'h0);
    RST = 0; pipe3_en = 0; d_ren_i3 = 0; halt_i3 = 0; dhit = 0;
    step();

    foreach (tv[i]) begin
      flushed3 = tv[i].fl; pipe3_en = tv[i].pe;
      npc_i3 = tv[i].npc; alu_out_i3 = tv[i].alu; rdat2_i3 = tv[i].rd2; LUI_i3 = tv[i].lui;
      W_mux_i3 = tv[i].wm; wsel_i3 = tv[i].ws; wen_i3 = tv[i].we;
      step();
      chk($sformatf("vec%0d_o3", i), o3(), tv[i].exp);
      chk($sformatf("vec%0d_req", i), {mem_stall, dmemREN, dmemWEN}, 3'b0);
    end
    flushed3 = 0; pipe3_en = 0;

    // load, 3 wait cycles, pipe3_en pulses ignored
    launch(1, 0, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("load_busy%0d", i), {mem_stall, dmemREN, dmemWEN, dmemaddr}, {3'b110, 32'h100});
      pipe3_en = 1; alu_out_i3 = 32'h999;
      dhit = (i == 3); dmemload = (i == 3) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      step();
    end
    pipe3_en = 0; dhit = 0;
    chk("load_done", {mem_stall, dmemREN, dmemWEN}, 3'b0);
    chk("load_data", dmemload_o3, 32'hDEADBEEF);
    chk("load_addr_held", alu_out_o3, 32'h100);

    // store, flush during BUSY ignored
    launch(0, 1, 32'h200, 32'h12345678);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("store_busy%0d", i), {mem_stall, dmemREN, dmemWEN, dmemaddr, dmemstore},
          {3'b101, 32'h200, 32'h12345678});
      flushed3 = 1; dhit = (i == 1); dmemload = 32'h0BAD0BAD;
      step();
    end
    flushed3 = 0; dhit = 0;
    chk("store_done", {mem_stall, dmemWEN}, 2'b0);
    chk("store_load_kept", dmemload_o3, 32'hDEADBEEF);
    chk("store_not_flushed", {alu_out_o3, rdat2_o3}, {32'h200, 32'h12345678});

    // dhit while idle ignored
    dhit = 1; dmemload = 32'h77;
    step();
    dhit = 0;
    chk("idle_dhit", {mem_stall, dmemload_o3}, {1'b0, 32'hDEADBEEF});

    // read+write together is a write
    launch(1, 1, 32'h300, 32'hCAFE);
    chk("rw_is_write", {mem_stall, dmemREN, dmemWEN}, 3'b101);
    dhit = 1; dmemload = 32'h55555555;
    step();
    dhit = 0;
    chk("rw_load_kept", {mem_stall, dmemload_o3}, {1'b0, 32'hDEADBEEF});

    // sticky halt
    pipe3_en = 1; halt_i3 = 1; alu_out_i3 = 32'h44;
    step();
    halt_i3 = 0;
    chk("halt_latch", {halt_o3, alu_out_o3}, {1'b1, 32'h44});
    alu_out_i3 = 32'h55; d_ren_i3 = 1;
    step();
    chk("halt_hold", {halt_o3, alu_out_o3, mem_stall, dmemREN}, {1'b1, 32'h44, 2'b00});
    pipe3_en = 0; d_ren_i3 = 0; flushed3 = 1;
    step();
    flushed3 = 0;
    chk("halt_noflush", {halt_o3, alu_out_o3}, {1'b1, 32'h44});
    do_reset();
    chk("halt_cleared", {halt_o3, alu_out_o3}, 33'h0);

    // reset mid-access
    launch(1, 0, 32'h400, 32'h0);
    dhit = 1; dmemload = 32'hA5A5A5A5;
    step();
    dhit = 0;
    chk("pre_rst_load", dmemload_o3, 32'hA5A5A5A5);
    launch(1, 0, 32'h404, 32'h0);
    chk("pre_rst_busy", {mem_stall, dmemREN}, 2'b11);
    do_reset();
    chk("mid_rst", {mem_stall, dmemREN, dmemWEN, dmemload_o3}, 35'h0);

`ifdef MEM_TIMEOUT_EN
    launch(1, 0, 32'h500, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_busy%0d", i), {mem_stall, mem_err}, 2'b10);
      step();
    end
    chk("to_fired", {mem_err, halt_o3, dmemREN, mem_stall}, 4'b1100);
    do_reset();
    launch(1, 0, 32'h504, 32'h0);
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3); dmemload = 32'h600D;
      step();
    end
    dhit = 0;
    chk("to_dhit_wins", {mem_err, halt_o3, mem_stall, dmemload_o3}, {3'b000, 32'h600D});
`else
    launch(1, 0, 32'h500, 32'h0);
    for (int i = 0; i < 8; i++) step();
    chk("no_timeout", {mem_stall, dmemREN, mem_err, halt_o3}, 4'b1100);
    dhit = 1; dmemload = 32'h600D;
    step();
    dhit = 0;
    chk("late_dhit", {mem_stall, dmemload_o3}, {1'b0, 32'h600D});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
